// File: rtl/level_qty_updater.sv
// level_qty_updater
//   Read-modify-write engine for the order-book price-level quantity memory.
//   One level command is taken at a time. The engine reads the level's
//   quantity from the single-port BRAM, applies ADD / CANCEL / SET / QUERY,
//   writes the result back and reports it on the res_* outputs.
//
//   Optional build macro: LEVEL_INIT_EN
//     defined   - every reset zeroes the whole memory (INIT sweep) before the
//                 first command is accepted; init_busy is high during the sweep.
//     undefined - no INIT state; init_busy is tied to 0.
//
//   Ports
//     clk, rst_n          clock, synchronous active-low reset
//     cmd_valid/cmd_ready command handshake; cmd_op 00 ADD 01 CANCEL 10 SET 11 QUERY
//     cmd_addr, cmd_qty   level index and operand quantity
//     bram_we/addr/wdata  BRAM write port (this block is the only master)
//     bram_rdata          BRAM read data, one-cycle registered read
//     res_valid           one-cycle pulse; res_addr/res_qty/res_flag valid
//     res_flag            CANCEL underflow or ADD saturation
//     init_busy           INIT sweep in progress
//
//   state | meaning
//   INIT  | zeroing memory, one address per cycle
//   IDLE  | ready for a command
//   RD    | BRAM address driven, read in flight
//   WR    | old quantity on bram_rdata, new value written, result registered
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module level_qty_updater #(
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_qty,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_qty,
  output logic              res_flag,
  output logic              init_busy
);

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_CANCEL = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_QUERY  = 2'b11;

`ifdef LEVEL_INIT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_INIT = 2'd3} state_t;
  localparam state_t S_RESET = S_INIT;
  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;
  localparam state_t S_RESET = S_IDLE;
`endif

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] qty_q, qty_d;
  logic              res_valid_q, res_valid_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;
  logic [DATA_W-1:0] res_qty_q, res_qty_d;
  logic              res_flag_q, res_flag_d;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] new_qty;
  logic              upd_flag;

  // New level quantity from the old value now on bram_rdata.
  always_comb begin
    sum      = {1'b0, bram_rdata} + {1'b0, qty_q};
    new_qty  = bram_rdata;
    upd_flag = 1'b0;
    case (op_q)
      OP_ADD: begin
        if (sum[DATA_W]) begin
          new_qty  = '1;
          upd_flag = 1'b1;
        end else begin
          new_qty = sum[DATA_W-1:0];
        end
      end
      OP_CANCEL: begin
        if (qty_q > bram_rdata) begin
          new_qty  = '0;
          upd_flag = 1'b1;
        end else begin
          new_qty = bram_rdata - qty_q;
        end
      end
      OP_SET:   new_qty = qty_q;
      default:  new_qty = bram_rdata;
    endcase
  end

  // Outputs are gated with rst_n so nothing reaches the BRAM while reset is
  // held: an uncommitted WR write is dropped and INIT does not start early.
  assign cmd_ready = rst_n && (state_q == S_IDLE);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    qty_d       = qty_q;
    res_valid_d = 1'b0;
    res_addr_d  = res_addr_q;
    res_qty_d   = res_qty_q;
    res_flag_d  = res_flag_q;
    bram_we     = 1'b0;
    bram_addr   = '0;
    bram_wdata  = '0;
`ifdef LEVEL_INIT_EN
    init_cnt_d  = init_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          qty_d   = cmd_qty;
          state_d = S_RD;
        end
      end
      S_RD: begin
        bram_addr = addr_q;
        state_d   = S_WR;
      end
      S_WR: begin
        bram_addr = addr_q;
        if (op_q != OP_QUERY) begin
          bram_we    = 1'b1;
          bram_wdata = new_qty;
        end
        res_valid_d = 1'b1;
        res_addr_d  = addr_q;
        res_qty_d   = new_qty;
        res_flag_d  = upd_flag;
        state_d     = S_IDLE;
      end
`ifdef LEVEL_INIT_EN
      S_INIT: begin
        bram_we    = 1'b1;
        bram_addr  = init_cnt_q;
        init_cnt_d = init_cnt_q + ONE_A;
        if (init_cnt_q == '1) state_d = S_IDLE;
      end
`endif
      default: state_d = S_RESET;
    endcase
    if (!rst_n) begin
      bram_we    = 1'b0;
      bram_addr  = '0;
      bram_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      op_q        <= '0;
      addr_q      <= '0;
      qty_q       <= '0;
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
      res_qty_q   <= '0;
      res_flag_q  <= 1'b0;
`ifdef LEVEL_INIT_EN
      init_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      qty_q       <= qty_d;
      res_valid_q <= res_valid_d;
      res_addr_q  <= res_addr_d;
      res_qty_q   <= res_qty_d;
      res_flag_q  <= res_flag_d;
`ifdef LEVEL_INIT_EN
      init_cnt_q  <= init_cnt_d;
`endif
    end
  end

  assign res_valid = res_valid_q;
  assign res_addr  = res_addr_q;
  assign res_qty   = res_qty_q;
  assign res_flag  = res_flag_q;

`ifdef LEVEL_INIT_EN
  assign init_busy = (state_q == S_INIT);
`else
  assign init_busy = 1'b0;
`endif

endmodule

// File: tb/tb_level_qty_updater.sv
module tb_level_qty_updater;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_qty;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata;
  logic [DW-1:0] bram_rdata;
  logic          res_valid;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_qty;
  logic          res_flag;
  logic          init_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  level_qty_updater dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_qty(cmd_qty),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata),
    .res_valid(res_valid), .res_addr(res_addr), .res_qty(res_qty),
    .res_flag(res_flag), .init_busy(init_busy)
  );

  // Single-port BRAM model with registered read (read-before-write).
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_wdata;
    bram_rdata <= mem[bram_addr];
  end

  localparam logic [1:0] ADD = 2'b00, CANCEL = 2'b01, SET = 2'b10, QUERY = 2'b11;

  // Issues one command starting at negedge+1 and returns at negedge+1 of the
  // cycle res_valid is seen. lat = cycles from accept edge to result (0 if none),
  // wes = cycles with bram_we high, wt = cycles waited for cmd_ready.
  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] q,
                         output logic [DW-1:0] rq, output logic rf, output logic [AW-1:0] ra,
                         output int lat, output int wes, output int wt, output logic rdy);
    rq = '0; rf = 1'b0; ra = '0; lat = 0; wes = 0; wt = 0; rdy = 1'b0;
    while (!cmd_ready && wt < 2000) begin
      @(negedge clk); #1; wt++;
    end
    if (!cmd_ready) return;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_qty = q;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      #1;
      if (bram_we) wes++;
      if (res_valid) begin
        lat = k; rq = res_qty; rf = res_flag; ra = res_addr; rdy = cmd_ready;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_qty = '0;
    repeat (5) @(negedge clk);
    #1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
    total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL rst_bram_we got %b want 0", bram_we); end
    total++; if (bram_addr !== '0) begin bad++; $display("FAIL rst_bram_addr got %0h want 0", bram_addr); end
    total++; if (bram_wdata !== '0) begin bad++; $display("FAIL rst_bram_wdata got %0h want 0", bram_wdata); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    total++; if (res_addr !== '0) begin bad++; $display("FAIL rst_res_addr got %0h want 0", res_addr); end
    total++; if (res_qty !== '0) begin bad++; $display("FAIL rst_res_qty got %0h want 0", res_qty); end
    total++; if (res_flag !== 1'b0) begin bad++; $display("FAIL rst_res_flag got %b want 0", res_flag); end
`ifdef LEVEL_INIT_EN
    total++; if (init_busy !== 1'b1) begin bad++; $display("FAIL rst_init_busy got %b want 1", init_busy); end
`else
    total++; if (init_busy !== 1'b0) begin bad++; $display("FAIL rst_init_busy got %b want 0", init_busy); end
`endif
  endtask

  task automatic test_release;
    logic [DW-1:0] rq; logic rf; logic [AW-1:0] ra; int lat, wes, wt; logic rdy;
    int errs;
    @(negedge clk);
    rst_n = 1'b1;
`ifdef LEVEL_INIT_EN
    errs = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (bram_we !== 1'b1 || bram_addr !== AW'(i) || bram_wdata !== '0 ||
          init_busy !== 1'b1 || cmd_ready !== 1'b0) errs++;
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL init_sweep bad_cycles got %0d want 0", errs); end
    @(negedge clk); #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL init_ready_at_1024 got %b want 1", cmd_ready); end
    total++; if (init_busy !== 1'b0) begin bad++; $display("FAIL init_busy_done got %b want 0", init_busy); end
    run_cmd(QUERY, 10'd1023, 32'd0, rq, rf, ra, lat, wes, wt, rdy);
    total++; if (lat !== 3) begin bad++; $display("FAIL init_query_lat got %0d want 3", lat); end
    total++; if (rq !== 32'd0) begin bad++; $display("FAIL init_query_qty got %0h want 0", rq); end
`else
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL release_ready got %b want 1", cmd_ready); end
    total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL release_bram_we got %b want 0", bram_we); end
`endif
  endtask

  task automatic test_add_chain;
    logic [DW-1:0] rq; logic rf; logic [AW-1:0] ra; int lat, wes, wt; logic rdy;
    run_cmd(SET, 10'd5, 32'd0, rq, rf, ra, lat, wes, wt, rdy);
    run_cmd(ADD, 10'd5, 32'd100, rq, rf, ra, lat, wes, wt, rdy);
    total++; if (lat !== 3) begin bad++; $display("FAIL add1_lat got %0d want 3", lat); end
    total++; if (rq !== 32'd100) begin bad++; $display("FAIL add1_qty got %0d want 100", rq); end
    total++; if (rf !== 1'b0) begin bad++; $display("FAIL add1_flag got %b want 0", rf); end
    total++; if (ra !== 10'd5) begin bad++; $display("FAIL add1_addr got %0d want 5", ra); end
    total++; if (wes !== 1) begin bad++; $display("FAIL add1_we_cycles got %0d want 1", wes); end
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL add1_ready_with_result got %b want 1", rdy); end
    run_cmd(ADD, 10'd5, 32'd50, rq, rf, ra, lat, wes, wt, rdy);
    total++; if (wt !== 0) begin bad++; $display("FAIL add2_accept_wait got %0d want 0", wt); end
    total++; if (lat !== 3) begin bad++; $display("FAIL add2_lat got %0d want 3", lat); end
    total++; if (rq !== 32'd150) begin bad++; $display("FAIL add2_qty got %0d want 150", rq); end
    total++; if (rf !== 1'b0) begin bad++; $display("FAIL add2_flag got %b want 0", rf); end
  endtask

  task automatic test_cancel;
    logic [DW-1:0] rq; logic rf; logic [AW-1:0] ra; int lat, wes, wt; logic rdy;
    run_cmd(SET, 10'd7, 32'd30, rq, rf, ra, lat, wes, wt, rdy);
    total++; if (rq !== 32'd30 || rf !== 1'b0) begin bad++; $display("FAIL set7 got %0d/%b want 30/0", rq, rf); end
    run_cmd(CANCEL, 10'd7, 32'd40, rq, rf, ra, lat, wes, wt, rdy);
    total++; if (rq !== 32'd0) begin bad++; $display("FAIL cancel_under_qty got %0d want 0", rq); end
    total++; if (rf !== 1'b1) begin bad++; $display("FAIL cancel_under_flag got %b want 1", rf); end
    run_cmd(QUERY, 10'd7, 32'd0, rq, rf, ra, lat, wes, wt, rdy);
    total++; if (rq !== 32'd0 || rf !== 1'b0) begin bad++; $display("FAIL query7 got %0d/%b want 0/0", rq, rf); end
    run_cmd(SET, 10'd7, 32'd30, rq, rf, ra, lat, wes, wt, rdy);
    run_cmd(CANCEL, 10'd7, 32'd10, rq, rf, ra, lat, wes, wt, rdy);
    total++; if (rq !== 32'd20 || rf !== 1'b0) begin bad++; $display("FAIL cancel_part got %0d/%b want 20/0", rq, rf); end
    run_cmd(SET, 10'd7, 32'd30, rq, rf, ra, lat, wes, wt, rdy);
    run_cmd(CANCEL, 10'd7, 32'd30, rq, rf, ra, lat, wes, wt, rdy);
    total++; if (rq !== 32'd0) begin bad++; $display("FAIL cancel_exact_qty got %0d want 0", rq); end
    total++; if (rf !== 1'b0) begin bad++; $display("FAIL cancel_exact_flag got %b want 0", rf); end
  endtask

  task automatic test_saturation;
    logic [DW-1:0] rq; logic rf; logic [AW-1:0] ra; int lat, wes, wt; logic rdy;
    run_cmd(SET, 10'd2, 32'hFFFF_FFF0, rq, rf, ra, lat, wes, wt, rdy);
    run_cmd(ADD, 10'd2, 32'h0000_000F, rq, rf, ra, lat, wes, wt, rdy);
    total++; if (rq !== 32'hFFFF_FFFF || rf !== 1'b0) begin bad++; $display("FAIL add_to_max got %0h/%b want ffffffff/0", rq, rf); end
    run_cmd(SET, 10'd2, 32'hFFFF_FFF0, rq, rf, ra, lat, wes, wt, rdy);
    run_cmd(ADD, 10'd2, 32'h0000_0020, rq, rf, ra, lat, wes, wt, rdy);
    total++; if (rq !== 32'hFFFF_FFFF) begin bad++; $display("FAIL add_sat_qty got %0h want ffffffff", rq); end
    total++; if (rf !== 1'b1) begin bad++; $display("FAIL add_sat_flag got %b want 1", rf); end
    run_cmd(QUERY, 10'd2, 32'd0, rq, rf, ra, lat, wes, wt, rdy);
    total++; if (rq !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_stored got %0h want ffffffff", rq); end
  endtask

  task automatic test_query;
    logic [DW-1:0] rq; logic rf; logic [AW-1:0] ra; int lat, wes, wt; logic rdy;
    run_cmd(SET, 10'd9, 32'd77, rq, rf, ra, lat, wes, wt, rdy);
    total++; if (wes !== 1) begin bad++; $display("FAIL set9_we_cycles got %0d want 1", wes); end
    run_cmd(QUERY, 10'd9, 32'd5, rq, rf, ra, lat, wes, wt, rdy);
    total++; if (wes !== 0) begin bad++; $display("FAIL query_we_cycles got %0d want 0", wes); end
    total++; if (rq !== 32'd77) begin bad++; $display("FAIL query_qty got %0d want 77", rq); end
    total++; if (ra !== 10'd9) begin bad++; $display("FAIL query_addr got %0d want 9", ra); end
    @(negedge clk); #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL res_pulse_width got %b want 0", res_valid); end
    total++; if (res_qty !== 32'd77) begin bad++; $display("FAIL res_hold_qty got %0d want 77", res_qty); end
  endtask

  task automatic test_reset_mid_cmd;
    logic [DW-1:0] rq; logic rf; logic [AW-1:0] ra; int lat, wes, wt; logic rdy;
    int w, pulses;
    run_cmd(SET, 10'd3, 32'd0, rq, rf, ra, lat, wes, wt, rdy);
    w = 0;
    while (!cmd_ready && w < 100) begin @(negedge clk); #1; w++; end
    cmd_valid = 1'b1; cmd_op = ADD; cmd_addr = 10'd3; cmd_qty = 32'd10;
    @(posedge clk);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk); #1;
    total++; if (bram_we !== 1'b1) begin bad++; $display("FAIL mid_wr_we got %b want 1", bram_we); end
    rst_n = 1'b0; #1;
    total++; if (bram_we !== 1'b0) begin bad++; $display("FAIL mid_rst_we got %b want 0", bram_we); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (res_valid) pulses++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (res_valid) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_rst_res_valid got %0d want 0", pulses); end
    run_cmd(QUERY, 10'd3, 32'd0, rq, rf, ra, lat, wes, wt, rdy);
    total++; if (lat !== 3) begin bad++; $display("FAIL mid_rst_query_lat got %0d want 3", lat); end
    total++; if (rq !== 32'd0) begin bad++; $display("FAIL mid_rst_query_qty got %0d want 0", rq); end
  endtask

  initial begin
    test_reset();
    test_release();
    test_add_chain();
    test_cancel();
    test_saturation();
    test_query();
    test_reset_mid_cmd();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
